// File: rtl/shifter_iter_if.sv
// Start/done handshake bundle for the iterative shifter.
// The requester drives through master; the shifter attaches through slave.
interface shifter_iter_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         start;
    logic [N-1:0] In;
    logic [C-1:0] Cnt;
    logic [1:0]   Op;
    logic         BTR;
    logic         busy;
    logic         done;
    logic [N-1:0] Out;

    modport master (output start, In, Cnt, Op, BTR, input busy, done, Out);
    modport slave  (input start, In, Cnt, Op, BTR, output busy, done, Out);
endinterface

// File: rtl/shifter_iter.sv
// Iterative shifter/rotator: moves one bit per clock, or up to four per clock
// when SHIFTER_ITER_RADIX4_EN is defined. Results always match the barrel shifter.
//
//   state | meaning
//   IDLE  | waiting for start; operand and count loaded on acceptance
//   SHIFT | Out moves by amt each cycle while the count runs down
//   DONE  | done pulse for one cycle, Out holds
module shifter_iter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input logic           clk,
    input logic           rst_n,
    shifter_iter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] out_q;
    logic [C-1:0] count;
    logic [C-1:0] amt;
    logic [1:0]   op_q;
    logic         busy_q;
    logic         done_q;

`ifdef SHIFTER_ITER_RADIX4_EN
    assign amt = (count > C'(4)) ? C'(4) : count;
`else
    assign amt = C'(1);
`endif

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    // amt is never zero in SHIFT, so the complementary shift by N-amt stays in range
    function automatic logic [N-1:0] step(input logic [N-1:0] v,
                                          input logic [1:0]   op,
                                          input logic [C-1:0] s);
        int a;
        a = int'(s);
        case (op)
            2'b00:   return (v << a) | (v >> (N - a));
            2'b01:   return v << a;
            2'b10:   return (v >> a) | (v << (N - a));
            default: return v >> a;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            out_q  <= '0;
            count  <= '0;
            op_q   <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.Op;
                        busy_q <= 1'b1;
                        if (bus.BTR) begin
                            out_q <= bit_rev(bus.In);
                            count <= '0;
                        end else begin
                            out_q <= bus.In;
                            count <= bus.Cnt;
                        end
                        if (bus.BTR || bus.Cnt == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    out_q <= step(out_q, op_q, amt);
                    count <= count - amt;
                    if (count == amt) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shifter_iter.sv
// Scoreboard bench for shifter_iter: expected results are queued at start and
// popped when done appears; latency, busy width and hold behaviour are checked.
module tb_shifter_iter;
    localparam int N = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [N-1:0] sb[$];

    shifter_iter_if #(.N(N), .C(C)) bus ();

    shifter_iter #(.N(N), .C(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] in, input logic [C-1:0] cnt,
                                           input logic [1:0] op, input logic btr);
        logic [N-1:0] r;
        int s;
        s = int'(cnt);
        if (btr) begin
            for (int i = 0; i < N; i++) r[i] = in[N-1-i];
        end else begin
            case (op)
                2'b00:   r = (in << s) | (in >> (N - s));
                2'b01:   r = in << s;
                2'b10:   r = (in >> s) | (in << (N - s));
                default: r = in >> s;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [C-1:0] cnt, input logic btr);
        if (btr || cnt == '0) return 1;
`ifdef SHIFTER_ITER_RADIX4_EN
        return (int'(cnt) + 3) / 4 + 1;
`else
        return int'(cnt) + 1;
`endif
    endfunction

    // glitch_at > 0 re-asserts start with a fresh operand in that cycle of the op
    task automatic do_op(input logic [N-1:0] in, input logic [C-1:0] cnt,
                         input logic [1:0] op, input logic btr, input int glitch_at);
        int lat;
        int busy_n;
        int want;
        logic [N-1:0] exp;
        logic [N-1:0] got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.In    = in;
        bus.Cnt   = cnt;
        bus.Op    = op;
        bus.BTR   = btr;
        sb.push_back(model(in, cnt, op, btr));
        want = exp_latency(cnt, btr);
        @(negedge clk);
        lat    = 1;
        busy_n = 0;
        while (lat < 40) begin
            if (bus.busy) busy_n++;
            if (bus.done) break;
            bus.start = (lat == glitch_at);
            bus.In    = N'($urandom);
            bus.Cnt   = C'($urandom);
            bus.Op    = 2'($urandom);
            bus.BTR   = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("latency", lat, want);
        check("busy_cycles", busy_n, want);
        got = bus.Out;
        exp = sb.pop_front();
        check("out_at_done", got, exp);
        @(negedge clk);
        check("done_width", bus.done, 1'b0);
        check("busy_after", bus.busy, 1'b0);
        check("out_hold", bus.Out, exp);
    endtask

    initial begin
        int seen;
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Cnt   = '0;
        bus.Op    = 2'b00;
        bus.BTR   = 1'b0;
        #12;
        check("rst_out", bus.Out, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h8001, 4'd4, 2'b00, 1'b0, 0);
        check("rotl_const", bus.Out, 16'h0018);
        do_op(16'hFFFF, 4'd15, 2'b11, 1'b0, 0);
        check("srl_max", bus.Out, 16'h0001);
        do_op(16'h0001, 4'd9, 2'b10, 1'b1, 0);
        check("btr_const", bus.Out, 16'h8000);
        do_op(16'hA0A0, 4'd0, 2'b01, 1'b0, 0);
        check("cnt0_const", bus.Out, 16'hA0A0);
        do_op(16'h0003, 4'd8, 2'b10, 1'b0, 3);
        check("rotr_busy_start", bus.Out, 16'h0300);
        do_op(16'h1234, 4'd1, 2'b01, 1'b0, 0);
        check("after_ignored", bus.Out, 16'h2468);

        // reset in the middle of a Cnt=10 shift
        @(negedge clk);
        bus.start = 1'b1;
        bus.In    = 16'h00F0;
        bus.Cnt   = 4'd10;
        bus.Op    = 2'b01;
        bus.BTR   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out", bus.Out, 16'h0000);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("no_done_after_rst", seen, 0);
        do_op(16'hC003, 4'd2, 2'b00, 1'b0, 0);
        check("post_rst_op", bus.Out, 16'h000F);

        for (int i = 0; i < 2000; i++) begin
            do_op(N'($urandom), C'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shifter_iter.md
Name: shifter_iter

Overview:
Multi-cycle iterative shifter/rotator with a start/done handshake. It is the sequential counterpart of the single-cycle hierarchical barrel shifter, supporting the same op set and the same bit-reverse (BTR) override. It is used where area matters more than latency, such as a low-cost execute-unit variant or as a reference model in lockstep checks against the barrel shifter. One bit position moves per clock by default.

Parameters:
N, 16, data width in bits
C, 4, shift-count width in bits (max shift 2^C-1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
In  input  N  operand, latched on accepted start
Cnt  input  C  shift amount, latched on accepted start
Op  input  2  00 rotate left, 01 shift left, 10 rotate right, 11 shift right logical
BTR  input  1  1 = bit-reverse In; Op and Cnt are ignored
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; Out is valid
Out  output  N  working register; holds its value until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, Out=0, busy=0, done=0, internal count=0. Reset during a shift aborts it; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch op/BTR, load the count register with Cnt, and load Out:
  - BTR=1: Out <= reverse of In, with Out[i]=In[N-1-i] for all i, 0..N-1.
  - Otherwise: Out <= In.
  - Next state is DONE if BTR=1 or Cnt=0; otherwise SHIFT.
- SHIFT: each cycle Out moves one position per the latched Op and count decrements by 1.
  - Rotate left: Out <= {Out[N-2:0],Out[N-1]}.
  - Shift left: Out <= {Out[N-2:0],1'b0}.
  - Rotate right: Out <= {Out[0],Out[N-1:1]}.
  - Shift right logical: Out <= {1'b0,Out[N-1:1]}.
  - When count reaches 1 in SHIFT, the last step occurs and the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Out holds.
- Latency: with start accepted at edge k, done is high during cycle k+Cnt+1. For Cnt=0 or BTR=1, done is high in cycle k+1.
- busy=1 in SHIFT and DONE. start while busy=1 is ignored, with no queueing.
- start held high continuously: a new op is accepted on the first IDLE cycle after DONE, giving back-to-back throughput of Cnt+2 cycles.
- In/Cnt/Op/BTR changes after acceptance have no effect on the op in flight.
- Results match the combinational barrel shifter for every In/Cnt/Op/BTR.

Optional Feature:
- Macro: SHIFTER_ITER_RADIX4_EN.
- Defined: each SHIFT cycle moves min(4, count) positions and decrements count by that amount. done is high in cycle k+ceil(Cnt/4)+1. Results are identical.
- Undefined: 1 position per cycle as above.

Test Plan:
- Rotate left: In=16'h8001, Cnt=4, Op=00 -> Out=16'h0018. done high exactly 5 cycles after the start edge (radix4: 2), one cycle wide.
- Shift right logical, max count: In=16'hFFFF, Cnt=15, Op=11 -> Out=16'h0001 at done. busy high for 16 cycles.
- BTR with zero count: In=16'h0001, BTR=1, Cnt=9 -> Out=16'h8000 one cycle later. Op and Cnt are ignored. A second case with Cnt=0, Op=01, In=16'hA0A0 -> Out=16'hA0A0, done at k+1.
- Start while busy: start rotate right In=16'h0003, Cnt=8. Pulse start again at cycle k+3 with different In -> ignored. Out=16'h0300 at done. Next start is accepted only after returning to IDLE.
- Reset mid-op: assert rst_n=0 at cycle k+2 of a Cnt=10 shift -> Out=0, busy=0, done=0 immediately (async). No done pulse follows. The next start operates normally.
- Random regression: 2000 random In/Cnt/Op/BTR ops, each compared at done against the behavioural expressions In<<Cnt, In>>Cnt, and the rotates built from In<<Cnt|In>>(16-Cnt), plus full bit reverse. Zero mismatches required.
